// File: rtl/keypad_scan_queue.sv
// keypad_scan_queue: scans a 4x4 active-low keypad matrix, debounces whole
// scan frames and queues each new single-key press as a 4-bit code.
//   clock, reset     : system clock, asynchronous active-high reset
//   keypadCol[3:0]   : column sense, active-low
//   keypadRow[3:0]   : row drive, one-hot active-low
//   key_code[3:0]    : queue head, meaningful while key_valid
//   key_valid        : queue not empty
//   key_ready        : consumer accepts the head this cycle
//   key_held         : debounced state is a single pressed key
//   key_overflow     : one-cycle pulse when a press is dropped on a full queue
module keypad_scan_queue #(
    parameter int unsigned SCAN_DIV       = 250000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_overflow
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_e;
    typedef enum logic {S_IDLE, S_PRESSED} state_e;

    // Keypad legend indexed by {row index, column index}
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h7;  4'h1: code = 4'h4;  4'h2: code = 4'h1;  4'h3: code = 4'h0;
            4'h4: code = 4'h8;  4'h5: code = 4'h5;  4'h6: code = 4'h2;  4'h7: code = 4'hA;
            4'h8: code = 4'h9;  4'h9: code = 4'h6;  4'hA: code = 4'h3;  4'hB: code = 4'hB;
            4'hC: code = 4'hC;  4'hD: code = 4'hD;  4'hE: code = 4'hE;  default: code = 4'hF;
        endcase
        return code;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_q, row_d;
    logic [1:0]       acc_n_q, acc_n_d;
    logic [3:0]       acc_code_q, acc_code_d;
    res_kind_e        prev_kind_q, prev_kind_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             eval_q, eval_d;
    state_e           state_q, state_d;
    logic [3:0]       held_code_q, held_code_d;
    logic             push_q, push_d;
    logic [3:0]       push_code_q, push_code_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             ovf_q, ovf_d;

    logic             tc, row_ok;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       col_low, samp_code;
    logic [2:0]       low_n, sum_n;
    logic [1:0]       frame_n;
    logic [3:0]       frame_code, res_code;
    res_kind_e        frame_kind;
    logic             qualify, pop, full, wr_en;

    // Row divider, row sequencing and decode of the current column sample
    always_comb begin
        tc      = (div_q == DIV_MAX);
        div_d   = tc ? '0 : div_q + DIV_W'(1);
        row_ok  = 1'b1;
        row_idx = 2'd0;
        case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
        row_d = row_q;
        if (tc) begin
            case (row_q)
                4'b1110: row_d = 4'b1101;
                4'b1101: row_d = 4'b1011;
                4'b1011: row_d = 4'b0111;
                default: row_d = 4'b1110;   // wrap and recovery from illegal rows
            endcase
        end
        col_low = ~keypadCol;
        low_n   = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
        if (col_low[0])      col_idx = 2'd0;
        else if (col_low[1]) col_idx = 2'd1;
        else if (col_low[2]) col_idx = 2'd2;
        else                 col_idx = 2'd3;
        samp_code = key_map(row_idx, col_idx);
    end

    // Frame accumulation: saturating closed-contact count plus the lone code
    always_comb begin
        sum_n      = (row_idx == 2'd0) ? low_n : 3'(acc_n_q) + low_n;
        frame_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        frame_code = (low_n == 3'd1) ? samp_code : acc_code_q;
        case (frame_n)
            2'd0:    frame_kind = RES_NONE;
            2'd1:    frame_kind = RES_KEY;
            default: frame_kind = RES_MULTI;
        endcase
        res_code = (frame_kind == RES_KEY) ? frame_code : 4'd0;
    end

    // Debounce: compare each completed frame with the previous one
    always_comb begin
        acc_n_d     = acc_n_q;
        acc_code_d  = acc_code_q;
        prev_kind_d = prev_kind_q;
        prev_code_d = prev_code_q;
        db_cnt_d    = db_cnt_q;
        eval_d      = 1'b0;
        if (tc && row_ok) begin
            acc_n_d    = frame_n;
            acc_code_d = frame_code;
            if (row_idx == 2'd3) begin
                eval_d = 1'b1;
                if (frame_kind == prev_kind_q && res_code == prev_code_q) begin
                    if (db_cnt_q != DB_MAX) db_cnt_d = db_cnt_q + DB_W'(1);
                end else begin
                    db_cnt_d = '0;
                end
                prev_kind_d = frame_kind;
                prev_code_d = res_code;
            end
        end
    end

    // Stable-state machine, evaluated the cycle after a frame completes
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        qualify     = eval_q && (db_cnt_q == DB_MAX) && (prev_kind_q != RES_MULTI);
        case (state_q)
            S_IDLE: begin
                if (qualify && prev_kind_q == RES_KEY) begin
                    state_d     = S_PRESSED;
                    held_code_d = prev_code_q;
                    push_d      = 1'b1;
                    push_code_d = prev_code_q;
                end
            end
            default: begin
                if (qualify) begin
                    if (prev_kind_q == RES_NONE) begin
                        state_d = S_IDLE;
                    end else if (prev_code_q != held_code_q) begin
                        held_code_d = prev_code_q;
                        push_d      = 1'b1;
                        push_code_d = prev_code_q;
                    end
                end
            end
        endcase
    end

    // Event queue; a pop frees the slot for a same-cycle push when full
    always_comb begin
        pop      = key_valid_q && key_ready;
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en    = push_q && (!full || pop);
        ovf_d    = push_q && full && !pop;
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = push_code_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        key_valid_d = (count_d != '0);
        key_code_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            row_q       <= 4'b1110;
            acc_n_q     <= '0;
            acc_code_q  <= '0;
            prev_kind_q <= RES_NONE;
            prev_code_q <= '0;
            db_cnt_q    <= '0;
            eval_q      <= 1'b0;
            state_q     <= S_IDLE;
            held_code_q <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            prev_kind_q <= prev_kind_d;
            prev_code_q <= prev_code_d;
            db_cnt_q    <= db_cnt_d;
            eval_q      <= eval_d;
            state_q     <= state_d;
            held_code_q <= held_code_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign keypadRow    = row_q;
    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign key_held     = (state_q == S_PRESSED);
    assign key_overflow = ovf_q;

endmodule

// File: doc/keypad_scan_queue.md
# keypad_scan_queue

Scans the 4x4 matrix keypad, debounces whole-keypad scan frames, and delivers each new key press as a 4-bit code through a small valid/ready event queue. It sits directly upstream of the dot-matrix display logic, which consumes one key code per handshake. It replaces free-running per-row sampling with qualified, lossless press events and flags drops explicitly.

## Interface
Parameters:
- SCAN_DIV, 250000: clock cycles each row is driven before its columns are sampled; must be ≥ 2.
- DEBOUNCE_SCANS, 4: consecutive identical scan frames required to change the stable key state; must be ≥ 1.
- FIFO_DEPTH, 4: event queue depth; must be a power of 2, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; forces all state to reset values.
- keypadCol, in, 4: column sense, active-low; bit i low = key in column i of the driven row is closed.
- keypadRow, out, 4: row drive, one-hot active-low.
- key_code, out, 4: code at the queue head; valid only while key_valid = 1.
- key_valid, out, 1: queue not empty.
- key_ready, in, 1: consumer accepts the head this cycle.
- key_held, out, 1: 1 while the debounced state is a single pressed key.
- key_overflow, out, 1: one-cycle pulse when a press event is dropped because the queue is full.

## Operation
- Reset values: keypadRow = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, key_overflow = 0. The divider, debounce counter and queue are empty/zero. The previous-frame result and the stable state are NONE.
- Row scan: the divider counts 0..SCAN_DIV-1. On the terminal-count cycle, keypadCol is sampled against the current row, and the row advances 1110→1101→1011→0111→1110. Any other row value recovers to 1110 on the next terminal count.
- Key map, given as {row, col} → code:
  - Row 1110, col 1110/1101/1011/0111 → 7/4/1/0.
  - Row 1101 → 8/5/2/A.
  - Row 1011 → 9/6/3/B.
  - Row 0111 → C/D/E/F.
- Frame: the four row samples starting at row 1110.
  - Frame result is NONE if there are zero low column bits.
  - It is KEY(code) if exactly one low bit occurs across the whole frame.
  - Otherwise it is MULTI.
- Debounce: evaluated on the terminal-count cycle of row 0111.
  - If the result equals the previous frame's result, the counter increments, saturating at DEBOUNCE_SCANS-1. Otherwise the counter clears to 0.
  - The previous-frame result is always updated.
  - When the counter reaches DEBOUNCE_SCANS-1 and the result is NONE or KEY, the stable state takes the result.
  - MULTI never changes the stable state.
  - With DEBOUNCE_SCANS = 1, every non-MULTI frame qualifies.
- Stable state machine has two states, IDLE (NONE) and PRESSED(code). key_held = 1 exactly in PRESSED.
  - IDLE → PRESSED(k): push k.
  - PRESSED(k) → PRESSED(j), j≠k: push j.
  - PRESSED → IDLE: no event.
  - PRESSED(k) → PRESSED(k): no event.
- Queue: FIFO with key_code = head entry.
  - Pop occurs when key_valid && key_ready.
  - Push when full: the code is discarded and key_overflow pulses. This is the only drop case.
  - Simultaneous push and pop when full: both occur, with no overflow.
  - Simultaneous push and pop when empty: the push is stored. The pop is not applicable because key_valid = 0.
  - key_ready while empty is ignored.
  - Order is strictly first-in-first-out.

## Timing
- The column sample point is SCAN_DIV-1 cycles after the row change, so the row has been settled the whole time.
- Frame period = 4·SCAN_DIV cycles.
- Press latency:
  - key_valid rises 2 cycles after the sampling edge of row 0111 in the qualifying frame.
  - The stable state and key_held register at edge +1.
  - The queue write registers at edge +2.
- The qualifying frame is the DEBOUNCE_SCANS-th consecutive identical frame.
- key_overflow asserts in the same cycle the rejected write would have registered.
- Pop: the head advances on the accepting edge. The next entry, or key_valid = 0, is visible in the following cycle. Throughput is one event per cycle.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, and queued events are lost. Scanning restarts at row 1110 with the divider at 0 after release.

## Test plan
All scenarios use SCAN_DIV = 4, DEBOUNCE_SCANS = 2, FIFO_DEPTH = 4.
- Reset then idle → keypadRow holds 1110 for 4 cycles, then 1101, 1011, 0111, repeating. All outputs stay 0.
- Hold the key-5 contact (col 1101 low when row = 1101) for 4 frames, key_ready = 1 → exactly one 1-cycle key_valid with key_code = 5. key_held rises after frame 2. Release → key_held falls after 2 NONE frames, with no further event.
- Key 9 contact present on alternating frames for 8 frames → counter never qualifies, so no key_valid and key_held = 0.
- Keys 7 and 8 held together for 4 frames (from IDLE) → MULTI, so no event and key_held stays 0. Then release 8 → event code 7.
- key_ready = 0; press and release 1, 2, 3, A, F in turn, each for 3 frames → key_overflow pulses once, on the F push. Then key_ready = 1 → codes 1, 2, 3, A on 4 consecutive cycles, then key_valid = 0.
- Assert reset for 1 cycle while key_valid = 1 and key_held = 1 → all outputs at reset values immediately. After release with no key pressed, no event appears.
